// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: debug FSM states and the default
// forward-select encoding (0 = register file, k+1 = forwarding source k).
package pipe_hazard_ctrl_pkg;

  localparam int NUM_FW_DEF   = 2;
  localparam int FW_SEL_W_DEF = $clog2(NUM_FW_DEF + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2,
    STEP  = 2'd3
  } haz_state_e;

  typedef logic [FW_SEL_W_DEF-1:0] fw_sel_t;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Register scoreboard for multi-cycle producers: per-register pending bits, an
// outstanding-op credit counter and a sticky error for completions of idle registers.
module pipe_hazard_ctrl_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter  int ADDR_W   = 5,
  parameter  int MAX_LONG = 4,
  localparam int NREG     = 1 << ADDR_W,
  localparam int CRED_W   = $clog2(MAX_LONG + 1)
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic              i_cmp_valid,
  input  logic [ADDR_W-1:0] i_cmp_rd,
  output logic [NREG-1:0]   o_pending,
  output logic [CRED_W-1:0] o_credit,
  output logic              o_sb_err
);

  logic [NREG-1:0]   r_pending;
  logic [CRED_W-1:0] r_credit;
  logic              r_err;
  logic              w_cmp_hit;

  assign w_cmp_hit = i_cmp_valid & r_pending[i_cmp_rd];

  // Clear is written before set so an issue to the completing register keeps it pending.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_pending <= {NREG{1'b0}};
      r_credit  <= {CRED_W{1'b0}};
      r_err     <= 1'b0;
    end else begin
      if (w_cmp_hit) begin
        r_pending[i_cmp_rd] <= 1'b0;
      end
      if (i_issue) begin
        r_pending[i_issue_rd] <= 1'b1;
      end
      if (i_issue && !w_cmp_hit) begin
        r_credit <= r_credit + CRED_W'(1);
      end else if (!i_issue && w_cmp_hit && (r_credit != {CRED_W{1'b0}})) begin
        r_credit <= r_credit - CRED_W'(1);
      end
      if (i_cmp_valid && !r_pending[i_cmp_rd]) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_credit  = r_credit;
  assign o_sb_err  = r_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the IF-ID-EX-ME pipeline with long-op scoreboard and debug halt FSM.
// Optional: define HAZ_PERF_CNT_EN to build the saturating ID stall-cycle counter on oStallCyc.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter  int ADDR_W   = 5,
  parameter  int NUM_FW   = NUM_FW_DEF,
  parameter  int MAX_LONG = 4,
  localparam int FW_SEL_W = $clog2(NUM_FW + 1),
  localparam int CRED_W   = $clog2(MAX_LONG + 1)
) (
  input  logic                     iClk,
  input  logic                     nRst,
  input  logic                     iId_valid,
  input  logic [ADDR_W-1:0]        iId_rs1,
  input  logic [ADDR_W-1:0]        iId_rs2,
  input  logic                     iId_use1,
  input  logic                     iId_use2,
  input  logic [ADDR_W-1:0]        iId_rd,
  input  logic                     iId_we,
  input  logic                     iId_long,
  input  logic                     iBrTrue,
  input  logic [NUM_FW-1:0]        iFw_valid,
  input  logic [NUM_FW-1:0]        iFw_we,
  input  logic [NUM_FW-1:0]        iFw_rdy,
  input  logic [NUM_FW*ADDR_W-1:0] iFw_rd,
  input  logic                     iCmp_valid,
  input  logic [ADDR_W-1:0]        iCmp_rd,
  input  logic                     iStall_IF,
  input  logic                     iStall_ME,
  input  logic                     iDbg_halt,
  input  logic                     iDbg_step,
  output logic                     oStall_IF,
  output logic                     oStall_ID,
  output logic                     oStall_EX,
  output logic                     oStall_ME,
  output logic                     oFlush_IF,
  output logic                     oFlush_EX,
  output logic [FW_SEL_W-1:0]      oFwS1_sel,
  output logic [FW_SEL_W-1:0]      oFwS2_sel,
  output logic                     oHalted,
  output logic                     oSbErr,
  output logic [31:0]              oStallCyc
);

  // Returns {load_use, sel}; the youngest matching source wins, so scan oldest-first.
  function automatic logic [FW_SEL_W:0] fw_find(
    input logic [ADDR_W-1:0]        rs,
    input logic [NUM_FW-1:0]        fv,
    input logic [NUM_FW-1:0]        fwe,
    input logic [NUM_FW-1:0]        frdy,
    input logic [NUM_FW*ADDR_W-1:0] frd
  );
    logic [FW_SEL_W:0] res;
    res = {(FW_SEL_W + 1){1'b0}};
    for (int k = NUM_FW - 1; k >= 0; k--) begin
      if (fv[k] && fwe[k] && (frd[k*ADDR_W +: ADDR_W] == rs)) begin
        res = {~frdy[k], FW_SEL_W'(k + 1)};
      end
    end
    return res;
  endfunction

  logic [(1<<ADDR_W)-1:0] w_pending;
  logic [CRED_W-1:0]      w_credit;
  logic                   w_chk1, w_chk2, w_pend1, w_pend2, w_cred_full, w_haz, w_issue;
  logic [FW_SEL_W:0]      w_f1, w_f2;
  logic                   w_empty, w_hold_all, w_drain;
  haz_state_e             r_state, w_next;

  assign w_chk1 = iId_valid & iId_use1 & (iId_rs1 != {ADDR_W{1'b0}});
  assign w_chk2 = iId_valid & iId_use2 & (iId_rs2 != {ADDR_W{1'b0}});
  assign w_f1   = w_chk1 ? fw_find(iId_rs1, iFw_valid, iFw_we, iFw_rdy, iFw_rd) : {(FW_SEL_W + 1){1'b0}};
  assign w_f2   = w_chk2 ? fw_find(iId_rs2, iFw_valid, iFw_we, iFw_rdy, iFw_rd) : {(FW_SEL_W + 1){1'b0}};

  // A register completing this cycle is written through the RF and is no longer a hazard.
  assign w_pend1     = w_chk1 & w_pending[iId_rs1] & ~(iCmp_valid & (iCmp_rd == iId_rs1));
  assign w_pend2     = w_chk2 & w_pending[iId_rs2] & ~(iCmp_valid & (iCmp_rd == iId_rs2));
  assign w_cred_full = iId_valid & iId_long & (w_credit == CRED_W'(MAX_LONG));
  assign w_haz       = w_f1[FW_SEL_W] | w_f2[FW_SEL_W] | w_pend1 | w_pend2 | w_cred_full;

  assign oStall_ME = iStall_ME | w_hold_all;
  assign oStall_EX = oStall_ME;
  assign oStall_ID = oStall_ME | w_haz;
  assign oStall_IF = oStall_ID | iStall_IF | w_drain;
  assign oFlush_EX = w_haz & ~oStall_EX;
  assign oFlush_IF = iBrTrue & iId_valid & ~oStall_ID;
  assign oFwS1_sel = w_f1[FW_SEL_W-1:0];
  assign oFwS2_sel = w_f2[FW_SEL_W-1:0];

  assign w_issue = iId_valid & iId_long & iId_we & (iId_rd != {ADDR_W{1'b0}}) & ~oStall_ID;

  pipe_hazard_ctrl_scoreboard #(
    .ADDR_W   (ADDR_W),
    .MAX_LONG (MAX_LONG)
  ) u_sb (
    .iClk        (iClk),
    .nRst        (nRst),
    .i_issue     (w_issue),
    .i_issue_rd  (iId_rd),
    .i_cmp_valid (iCmp_valid),
    .i_cmp_rd    (iCmp_rd),
    .o_pending   (w_pending),
    .o_credit    (w_credit),
    .o_sb_err    (oSbErr)
  );

  assign w_empty = ~(|iFw_valid) & ~iId_valid & (w_credit == {CRED_W{1'b0}});

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Releasing the halt takes precedence over a simultaneous step request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:   w_next = iDbg_halt ? DRAIN : RUN;
      DRAIN: w_next = w_empty ? HALT : DRAIN;
      HALT: begin
        if (!iDbg_halt) begin
          w_next = RUN;
        end else if (iDbg_step) begin
          w_next = STEP;
        end else begin
          w_next = HALT;
        end
      end
      STEP:    w_next = DRAIN;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    w_hold_all = 1'b0;
    w_drain    = 1'b0;
    case (r_state)
      DRAIN:   w_drain    = 1'b1;
      HALT:    w_hold_all = 1'b1;
      default: begin
        w_hold_all = 1'b0;
        w_drain    = 1'b0;
      end
    endcase
  end

  assign oHalted = w_hold_all;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cyc;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_stall_cyc <= 32'd0;
    end else if (oStall_ID && (r_state != HALT) && (r_stall_cyc != 32'hFFFF_FFFF)) begin
      r_stall_cyc <= r_stall_cyc + 32'd1;
    end
  end

  assign oStallCyc = r_stall_cyc;
`else
  assign oStallCyc = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random cycles,
// each checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int NUM_FW   = 2;
  localparam int MAX_LONG = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3;

  logic        clk = 1'b0;
  logic        nRst;
  logic        id_valid, use1, use2, we, lng, br;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  fw_valid, fw_we, fw_rdy;
  logic [9:0]  fw_rd;
  logic        cmp_valid;
  logic [4:0]  cmp_rd;
  logic        st_if, st_me, dbg_halt, dbg_step;
  logic        o_st_if, o_st_id, o_st_ex, o_st_me, o_fl_if, o_fl_ex, o_halted, o_sberr;
  logic [1:0]  o_sel1, o_sel2;
  logic [31:0] o_cyc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .iClk(clk), .nRst(nRst),
    .iId_valid(id_valid), .iId_rs1(rs1), .iId_rs2(rs2), .iId_use1(use1), .iId_use2(use2),
    .iId_rd(rd), .iId_we(we), .iId_long(lng), .iBrTrue(br),
    .iFw_valid(fw_valid), .iFw_we(fw_we), .iFw_rdy(fw_rdy), .iFw_rd(fw_rd),
    .iCmp_valid(cmp_valid), .iCmp_rd(cmp_rd), .iStall_IF(st_if), .iStall_ME(st_me),
    .iDbg_halt(dbg_halt), .iDbg_step(dbg_step),
    .oStall_IF(o_st_if), .oStall_ID(o_st_id), .oStall_EX(o_st_ex), .oStall_ME(o_st_me),
    .oFlush_IF(o_fl_if), .oFlush_EX(o_fl_ex), .oFwS1_sel(o_sel1), .oFwS2_sel(o_sel2),
    .oHalted(o_halted), .oSbErr(o_sberr), .oStallCyc(o_cyc)
  );

  typedef struct {
    logic        s_if, s_id, s_ex, s_me, f_if, f_ex, halted, sberr, sel_chk;
    logic [1:0]  sel1, sel2;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  bit          m_pend[32];
  int          m_credit;
  int          m_mode;
  bit          m_err;
  logic [31:0] m_cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          halt_lvl = 1'b0;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_credit = 0;
    m_mode   = M_RUN;
    m_err    = 1'b0;
    m_cyc    = 32'd0;
  endtask

  task automatic clr_in();
    id_valid = 1'b0; use1 = 1'b0; use2 = 1'b0; we = 1'b0; lng = 1'b0; br = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    fw_valid = 2'b00; fw_we = 2'b00; fw_rdy = 2'b00; fw_rd = 10'd0;
    cmp_valid = 1'b0; cmp_rd = 5'd0; st_if = 1'b0; st_me = 1'b0;
    dbg_halt = 1'b0; dbg_step = 1'b0;
  endtask

  // Derive this cycle's expected outputs from current inputs and model state, then advance the model.
  task automatic model_push();
    exp_t       e;
    logic [4:0] rsv[2];
    bit         usev[2], lu[2], pd[2], found, full, haz, issue, hit, empty;
    int         sel[2];
    rsv[0] = rs1; rsv[1] = rs2; usev[0] = use1; usev[1] = use2;
    for (int s = 0; s < 2; s++) begin
      sel[s] = 0; lu[s] = 1'b0; pd[s] = 1'b0; found = 1'b0;
      if (id_valid && usev[s] && rsv[s] != 5'd0) begin
        for (int k = 0; k < NUM_FW; k++) begin
          if (!found && fw_valid[k] && fw_we[k] && fw_rd[k*5 +: 5] == rsv[s]) begin
            found = 1'b1; sel[s] = k + 1; lu[s] = !fw_rdy[k];
          end
        end
        pd[s] = m_pend[rsv[s]] && !(cmp_valid && cmp_rd == rsv[s]);
      end
    end
    full = id_valid && lng && (m_credit == MAX_LONG);
    haz  = lu[0] || lu[1] || pd[0] || pd[1] || full;
    e.s_me   = st_me || (m_mode == M_HALT);
    e.s_ex   = e.s_me;
    e.s_id   = e.s_me || haz;
    e.s_if   = e.s_id || st_if || (m_mode == M_DRAIN);
    e.f_ex   = haz && !e.s_ex;
    e.f_if   = br && id_valid && !e.s_id;
    e.sel1   = 2'(sel[0]);
    e.sel2   = 2'(sel[1]);
    e.sel_chk = !haz;
    e.halted = (m_mode == M_HALT);
    e.sberr  = m_err;
    e.cyc    = m_cyc;
    q.push_back(e);

    empty = (fw_valid == 2'b00) && !id_valid && (m_credit == 0);
`ifdef HAZ_PERF_CNT_EN
    if (e.s_id && m_mode != M_HALT && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
`endif
    issue = id_valid && lng && we && rd != 5'd0 && !e.s_id;
    hit   = cmp_valid && m_pend[cmp_rd];
    if (cmp_valid && !hit) m_err = 1'b1;
    if (hit) begin m_pend[cmp_rd] = 1'b0; m_credit = m_credit - 1; end
    if (issue) begin m_pend[rd] = 1'b1; m_credit = m_credit + 1; end
    case (m_mode)
      M_RUN:   m_mode = dbg_halt ? M_DRAIN : M_RUN;
      M_DRAIN: m_mode = empty ? M_HALT : M_DRAIN;
      M_HALT:  m_mode = !dbg_halt ? M_RUN : (dbg_step ? M_STEP : M_HALT);
      default: m_mode = M_DRAIN;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall_if", 32'(o_st_if), 32'(e.s_if));
      chk("stall_id", 32'(o_st_id), 32'(e.s_id));
      chk("stall_ex", 32'(o_st_ex), 32'(e.s_ex));
      chk("stall_me", 32'(o_st_me), 32'(e.s_me));
      chk("flush_if", 32'(o_fl_if), 32'(e.f_if));
      chk("flush_ex", 32'(o_fl_ex), 32'(e.f_ex));
      chk("halted",   32'(o_halted), 32'(e.halted));
      chk("sb_err",   32'(o_sberr), 32'(e.sberr));
      chk("stall_cyc", o_cyc, e.cyc);
      if (e.sel_chk) begin
        chk("fw_s1_sel", 32'(o_sel1), 32'(e.sel1));
        chk("fw_s2_sel", 32'(o_sel2), 32'(e.sel2));
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    clr_in();
    nRst = 1'b0;
    model_reset();
    model_push();
    @(negedge clk);
    #1;
    nRst = 1'b1;
  endtask

  task automatic rand_cycle();
    bit quiet;
    int plist[$];
    int r;
    nc();
    quiet = (m_mode == M_DRAIN || m_mode == M_HALT) && ($urandom_range(0, 3) != 0);
    for (int i = 1; i < 32; i++) if (m_pend[i]) plist.push_back(i);
    if (plist.size() > 0 && $urandom_range(0, 2) == 0) begin
      cmp_valid = 1'b1;
      cmp_rd    = 5'(plist[$urandom_range(0, plist.size() - 1)]);
    end
    id_valid = !quiet && ($urandom_range(0, 3) != 0);
    rs1 = 5'($urandom_range(0, 9)); rs2 = 5'($urandom_range(0, 9));
    use1 = 1'($urandom_range(0, 1)); use2 = 1'($urandom_range(0, 1));
    we  = ($urandom_range(0, 3) != 0);
    lng = ($urandom_range(0, 3) == 0);
    rd  = 5'($urandom_range(0, 15));
    if (lng) begin
      if (cmp_valid && $urandom_range(0, 7) == 0) begin
        rd = cmp_rd;
      end else begin
        for (int t = 0; t < 8; t++) begin
          r = $urandom_range(1, 15);
          if (!m_pend[r]) begin rd = 5'(r); break; end
        end
      end
    end
    fw_valid = quiet ? 2'b00 : 2'($urandom_range(0, 3));
    fw_we    = 2'($urandom_range(0, 3));
    fw_rdy   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
    fw_rd    = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
    br       = ($urandom_range(0, 3) == 0);
    st_if    = ($urandom_range(0, 7) == 0);
    st_me    = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 39) == 0) halt_lvl = !halt_lvl;
    dbg_halt = halt_lvl;
    dbg_step = (m_mode == M_HALT) && ($urandom_range(0, 3) == 0);
    model_push();
  endtask

  initial begin
    nRst = 1'b0;
    clr_in();
    model_reset();
    #1;
    model_push();
    #11;
    nRst = 1'b1;

    // Forward from EX, then load-use with ME also matching, then forward from ME.
    nc(); fw_valid = 2'b01; fw_we = 2'b01; fw_rdy = 2'b11; fw_rd = 10'd5;
    id_valid = 1'b1; rs1 = 5'd5; use1 = 1'b1; model_push();
    nc(); fw_valid = 2'b11; fw_we = 2'b11; fw_rdy = 2'b10; fw_rd = {5'd5, 5'd5};
    id_valid = 1'b1; rs1 = 5'd5; use1 = 1'b1; model_push();
    nc(); fw_valid = 2'b10; fw_we = 2'b10; fw_rdy = 2'b11; fw_rd = {5'd5, 5'd0};
    id_valid = 1'b1; rs1 = 5'd5; use1 = 1'b1; rs2 = 5'd5; use2 = 1'b1; model_push();

    // Long op to x7, consumer stalls until completion, then credit exhaustion.
    nc(); id_valid = 1'b1; lng = 1'b1; we = 1'b1; rd = 5'd7; model_push();
    repeat (3) begin nc(); id_valid = 1'b1; rs1 = 5'd7; use1 = 1'b1; model_push(); end
    nc(); id_valid = 1'b1; rs1 = 5'd7; use1 = 1'b1; cmp_valid = 1'b1; cmp_rd = 5'd7; model_push();
    for (int r = 10; r < 14; r++) begin
      nc(); id_valid = 1'b1; lng = 1'b1; we = 1'b1; rd = 5'(r); model_push();
    end
    nc(); id_valid = 1'b1; lng = 1'b1; we = 1'b1; rd = 5'd14; model_push();
    for (int r = 10; r < 14; r++) begin
      nc(); cmp_valid = 1'b1; cmp_rd = 5'(r); model_push();
    end

    // Issue and completion of the same register in one cycle.
    nc(); id_valid = 1'b1; lng = 1'b1; we = 1'b1; rd = 5'd8; model_push();
    nc(); id_valid = 1'b1; lng = 1'b1; we = 1'b1; rd = 5'd8; cmp_valid = 1'b1; cmp_rd = 5'd8; model_push();
    nc(); id_valid = 1'b1; rs1 = 5'd8; use1 = 1'b1; model_push();
    nc(); cmp_valid = 1'b1; cmp_rd = 5'd8; model_push();

    // Branch while ID is stalled, then unstalled.
    nc(); fw_valid = 2'b01; fw_we = 2'b01; fw_rdy = 2'b00; fw_rd = 10'd3;
    id_valid = 1'b1; rs1 = 5'd3; use1 = 1'b1; br = 1'b1; model_push();
    nc(); id_valid = 1'b1; br = 1'b1; model_push();

    // Halt with two in flight, single step, release; then step and release together.
    nc(); dbg_halt = 1'b1; fw_valid = 2'b11; id_valid = 1'b1; model_push();
    nc(); dbg_halt = 1'b1; fw_valid = 2'b11; model_push();
    nc(); dbg_halt = 1'b1; fw_valid = 2'b10; model_push();
    nc(); dbg_halt = 1'b1; model_push();
    nc(); dbg_halt = 1'b1; model_push();
    nc(); dbg_halt = 1'b1; dbg_step = 1'b1; model_push();
    nc(); dbg_halt = 1'b1; id_valid = 1'b1; model_push();
    nc(); dbg_halt = 1'b1; fw_valid = 2'b01; model_push();
    nc(); dbg_halt = 1'b1; model_push();
    nc(); dbg_halt = 1'b1; model_push();
    nc(); model_push();
    nc(); model_push();
    nc(); dbg_halt = 1'b1; model_push();
    nc(); dbg_halt = 1'b1; model_push();
    nc(); dbg_step = 1'b1; model_push();
    nc(); model_push();

    // Completion of an idle register, then reset in the middle of DRAIN.
    nc(); cmp_valid = 1'b1; cmp_rd = 5'd9; model_push();
    nc(); model_push();
    nc(); dbg_halt = 1'b1; id_valid = 1'b1; lng = 1'b1; we = 1'b1; rd = 5'd4; model_push();
    nc(); dbg_halt = 1'b1; fw_valid = 2'b01; model_push();
    reset_mid();
    nc(); model_push();
    nc(); id_valid = 1'b1; rs1 = 5'd4; use1 = 1'b1; model_push();

    for (int i = 0; i < 3000; i++) rand_cycle();

    nc(); model_push();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
